cmp_debounce_tracker: RTL and testbench
=======================================

CMP_DEBOUNCE_TRACKER -- requirements
Module: cmp_debounce_tracker

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive identical valid comparison results required to qualify a new stable result; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the change counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  comparison flags below are meaningful this cycle.
REQ-006 A_gt_B  input  1  upstream 16-bit comparator flag, A > B.
REQ-007 A_eq_B  input  1  upstream comparator flag, A == B.
REQ-008 A_lt_B  input  1  upstream comparator flag, A < B.
REQ-009 stable_res  output  2  qualified result: 00 NONE, 01 LT, 10 EQ, 11 GT.
REQ-010 res_valid  output  1  high once any result has been qualified.
REQ-011 change_pulse  output  1  one-cycle strobe on every stable_res update.
REQ-012 change_cnt  output  CNT_W  number of stable_res updates since reset.
REQ-013 flag_err  output  1  sticky error: illegal flag combination seen.

Function
REQ-014 Sample is legal when in_valid=1 and exactly one of A_gt_B/A_eq_B/A_lt_B is 1.
REQ-015 Internal state: cand (2-bit candidate code), run (8-bit run length), stable_res.
REQ-016 in_valid=0: cand and run hold; change_pulse=0.
REQ-017 Legal sample matching cand: run <= min(run+1, DEBOUNCE).
REQ-018 Legal sample differing from cand: cand <= sample code, run <= 1.
REQ-019 Qualification: when post-update run equals DEBOUNCE and post-update cand differs from stable_res, stable_res <= cand at the same edge.
REQ-020 Latency: stable_res and change_pulse are visible in the cycle after the edge on which the DEBOUNCE-th consecutive matching sample is sampled.
REQ-021 On qualification: change_pulse=1 for exactly one cycle; change_cnt increments by 1, wrapping from all-ones to 0; res_valid <= 1.
REQ-022 The first qualification from NONE counts as a change: pulse asserted, change_cnt incremented.
REQ-023 Run saturated at DEBOUNCE with cand equal to stable_res: no pulse, no count change.
REQ-024 Illegal sample (in_valid=1, zero or multiple flags set): flag_err <= 1, sticky until reset; cand <= NONE, run <= 0; stable_res, res_valid, change_cnt hold.
REQ-025 Flags are ignored while in_valid=0, whatever their values.
REQ-026 DEBOUNCE=1: every legal sample differing from stable_res qualifies at its own edge.
REQ-027 Interleaved in_valid=0 cycles do not break a run; only a differing or illegal valid sample does.
REQ-028 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-029 rst_n=0 asynchronously forces: stable_res=00, res_valid=0, change_pulse=0, change_cnt=0, flag_err=0, cand=NONE, run=0.
REQ-030 Reset asserted mid-run discards the partial run; after release, a full DEBOUNCE run is needed to qualify.
REQ-031 First sample is taken on the first rising edge after rst_n deasserts.

Verification (DEBOUNCE=4, CNT_W=16)
REQ-032 Four consecutive valid GT samples -> stable_res=11, res_valid=1, change_pulse high for one cycle after the 4th edge, change_cnt=1.
REQ-033 GT,GT,GT,LT,LT,LT,LT -> no qualification until the 4th LT; then stable_res=01, change_cnt=1.
REQ-034 EQ x4, then EQ x10 -> single pulse, change_cnt=1, run saturates.
REQ-035 in_valid=1 with A_gt_B=A_lt_B=1 after two EQ samples -> flag_err=1 and stays 1; stable_res unchanged; four more EQ samples are needed to qualify.
REQ-036 GT x2, reset pulse, GT x3 -> stable_res=00, res_valid=0; a 4th GT -> stable_res=11.
REQ-037 Alternating 4xGT and 4xLT blocks repeated 65536 times -> change_cnt wraps to 0; one pulse per block.

Source files
------------

// File: rtl/cmp_debounce_tracker.sv
// cmp_debounce_tracker
// Qualifies the result of an upstream magnitude comparator (GT/EQ/LT flags):
// a result becomes the stable result only after DEBOUNCE consecutive valid,
// legal samples agree. Every stable-result update strobes change_pulse and
// bumps a wrapping change counter. Illegal flag combinations raise a sticky
// error and discard the candidate run in progress.
module cmp_debounce_tracker #(
    parameter int DEBOUNCE = 4,    // 1..255
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             A_gt_B,
    input  logic             A_eq_B,
    input  logic             A_lt_B,
    output logic [1:0]       stable_res,
    output logic             res_valid,
    output logic             change_pulse,
    output logic [CNT_W-1:0] change_cnt,
    output logic             flag_err
);

    // Run length is 8 bits wide, so the debounce depth is clipped to 8 bits.
    localparam logic [7:0] DEB = 8'(DEBOUNCE);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_LT   = 2'b01;
    localparam logic [1:0] RES_EQ   = 2'b10;
    localparam logic [1:0] RES_GT   = 2'b11;

    logic [1:0] cand_reg;
    logic [1:0] cand_next;
    logic [7:0] run_reg;
    logic [7:0] run_next;
    logic [1:0] sample_code;
    logic       sample_legal;
    logic       sample_illegal;
    logic       qualify;

    // Decode the flag triple: exactly one flag set is a legal sample.
    always_comb begin
        sample_code  = RES_NONE;
        sample_legal = 1'b0;
        case ({A_gt_B, A_eq_B, A_lt_B})
            3'b100:  begin sample_code = RES_GT; sample_legal = 1'b1; end
            3'b010:  begin sample_code = RES_EQ; sample_legal = 1'b1; end
            3'b001:  begin sample_code = RES_LT; sample_legal = 1'b1; end
            default: begin sample_code = RES_NONE; sample_legal = 1'b0; end
        endcase
    end

    assign sample_illegal = in_valid && !sample_legal;

    // Candidate/run update and qualification decision for this edge.
    always_comb begin
        cand_next = cand_reg;
        run_next  = run_reg;
        qualify   = 1'b0;
        if (in_valid) begin
            if (sample_legal) begin
                if (sample_code == cand_reg) begin
                    // Saturate so a long steady input never re-qualifies.
                    run_next = (run_reg >= DEB) ? DEB : run_reg + 8'd1;
                end else begin
                    cand_next = sample_code;
                    run_next  = 8'd1;
                end
                // Qualification looks at the post-update run and candidate,
                // so the DEBOUNCE-th matching sample updates on its own edge.
                qualify = (run_next == DEB) && (cand_next != stable_res);
            end else begin
                cand_next = RES_NONE;
                run_next  = 8'd0;
            end
        end
    end

    // Candidate tracking state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_reg <= RES_NONE;
            run_reg  <= 8'd0;
        end else begin
            cand_reg <= cand_next;
            run_reg  <= run_next;
        end
    end

    // Registered outputs: stable result, strobe, counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_res   <= RES_NONE;
            res_valid    <= 1'b0;
            change_pulse <= 1'b0;
            change_cnt   <= '0;
            flag_err     <= 1'b0;
        end else begin
            change_pulse <= qualify;
            if (qualify) begin
                stable_res <= cand_next;
                res_valid  <= 1'b1;
                change_cnt <= change_cnt + 1'b1;
            end
            if (sample_illegal) begin
                flag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmp_debounce_tracker.sv
// Testbench for cmp_debounce_tracker: three instances share one stimulus
// stream (DEBOUNCE=4/CNT_W=16, DEBOUNCE=4/CNT_W=4 for counter wrap,
// DEBOUNCE=1/CNT_W=16). A history-queue reference model predicts outputs.
module tb_cmp_debounce_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic a_gt = 1'b0;
    logic a_eq = 1'b0;
    logic a_lt = 1'b0;

    logic [1:0]  d_stable, w_stable, o_stable;
    logic        d_valid, w_valid, o_valid;
    logic        d_pulse, w_pulse, o_pulse;
    logic [15:0] d_cnt, o_cnt;
    logic [3:0]  w_cnt;
    logic        d_err, w_err, o_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cmp_debounce_tracker #(.DEBOUNCE(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A_gt_B(a_gt), .A_eq_B(a_eq), .A_lt_B(a_lt),
        .stable_res(d_stable), .res_valid(d_valid), .change_pulse(d_pulse),
        .change_cnt(d_cnt), .flag_err(d_err));

    cmp_debounce_tracker #(.DEBOUNCE(4), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A_gt_B(a_gt), .A_eq_B(a_eq), .A_lt_B(a_lt),
        .stable_res(w_stable), .res_valid(w_valid), .change_pulse(w_pulse),
        .change_cnt(w_cnt), .flag_err(w_err));

    cmp_debounce_tracker #(.DEBOUNCE(1), .CNT_W(16)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .A_gt_B(a_gt), .A_eq_B(a_eq), .A_lt_B(a_lt),
        .stable_res(o_stable), .res_valid(o_valid), .change_pulse(o_pulse),
        .change_cnt(o_cnt), .flag_err(o_err));

    // Reference model, DEBOUNCE=4: last legal samples since reset/illegal.
    int          hist[$];
    logic [1:0]  m_stable;
    logic        m_valid, m_pulse, m_err;
    logic [15:0] m_cnt;
    // Reference model, DEBOUNCE=1: any legal sample differing qualifies.
    logic [1:0]  s_stable;
    logic        s_valid, s_pulse;
    logic [15:0] s_cnt;

    task automatic model_reset();
        hist.delete();
        m_stable = 2'b00; m_valid = 1'b0; m_pulse = 1'b0; m_err = 1'b0; m_cnt = 16'd0;
        s_stable = 2'b00; s_valid = 1'b0; s_pulse = 1'b0; s_cnt = 16'd0;
    endtask

    task automatic model_step(input logic v, input logic g, input logic e, input logic l);
        logic legal;
        logic same;
        int   code;
        legal = ({g, e, l} == 3'b100) || ({g, e, l} == 3'b010) || ({g, e, l} == 3'b001);
        code  = g ? 3 : (e ? 2 : 1);
        m_pulse = 1'b0;
        s_pulse = 1'b0;
        if (v && legal) begin
            hist.push_back(code);
            if (hist.size() > 4) hist.delete(0);
            same = (hist.size() == 4);
            foreach (hist[i]) if (hist[i] != code) same = 1'b0;
            if (same && code != int'(m_stable)) begin
                m_stable = 2'(code); m_valid = 1'b1; m_pulse = 1'b1; m_cnt = m_cnt + 16'd1;
            end
            if (code != int'(s_stable)) begin
                s_stable = 2'(code); s_valid = 1'b1; s_pulse = 1'b1; s_cnt = s_cnt + 16'd1;
            end
        end else if (v) begin
            m_err = 1'b1;
            hist.delete();
        end
    endtask

    // Apply one sample for one clock, advance the model, settle past the edge.
    task automatic drive(input logic v, input logic g, input logic e, input logic l);
        @(negedge clk);
        in_valid = v; a_gt = g; a_eq = e; a_lt = l;
        @(posedge clk);
        model_step(v, g, e, l);
        #1;
    endtask

    task automatic drive_code(input int code, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, code == 3, code == 2, code == 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        in_valid = 1'b1; a_gt = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({d_stable, d_valid, d_pulse, d_cnt, d_err} !== 21'd0)
            $display("FAIL reset_hold got st=%b v=%b p=%b cnt=%0d err=%b want all 0",
                     d_stable, d_valid, d_pulse, d_cnt, d_err);
        else n_pass++;
        in_valid = 1'b0; a_gt = 1'b0;
        rst_n = 1'b1;
        model_reset();
        drive_code(3, 4);
        // Asynchronous assertion mid-cycle must clear outputs without an edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({d_stable, d_valid, d_pulse, d_cnt, d_err} !== 21'd0)
            $display("FAIL reset_async got st=%b v=%b cnt=%0d want all 0", d_stable, d_valid, d_cnt);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        drive_code(3, 1);
        n_checks++;
        if (o_stable !== 2'b11 || o_pulse !== 1'b1 || o_cnt !== 16'd1)
            $display("FAIL d1_first got st=%b p=%b cnt=%0d want 11/1/1", o_stable, o_pulse, o_cnt);
        else n_pass++;
        drive_code(3, 2);
        n_checks++;
        if (d_stable !== 2'b00 || d_pulse !== 1'b0 || d_valid !== 1'b0)
            $display("FAIL basic_early got st=%b p=%b v=%b want 00/0/0", d_stable, d_pulse, d_valid);
        else n_pass++;
        drive_code(3, 1);
        n_checks++;
        if (d_stable !== 2'b11 || d_pulse !== 1'b1 || d_valid !== 1'b1 || d_cnt !== 16'd1)
            $display("FAIL basic_qual got st=%b p=%b v=%b cnt=%0d want 11/1/1/1",
                     d_stable, d_pulse, d_valid, d_cnt);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (d_pulse !== 1'b0 || d_stable !== 2'b11)
            $display("FAIL basic_pulse_width got p=%b st=%b want 0/11", d_pulse, d_stable);
        else n_pass++;
        $display("test_basic done");
    endtask

    task automatic test_change();
        do_reset();
        drive_code(3, 3);
        drive_code(1, 3);
        n_checks++;
        if (d_stable !== 2'b00 || d_cnt !== 16'd0)
            $display("FAIL change_early got st=%b cnt=%0d want 00/0", d_stable, d_cnt);
        else n_pass++;
        drive_code(1, 1);
        n_checks++;
        if (d_stable !== 2'b01 || d_cnt !== 16'd1 || d_pulse !== 1'b1)
            $display("FAIL change_qual got st=%b cnt=%0d p=%b want 01/1/1", d_stable, d_cnt, d_pulse);
        else n_pass++;
        $display("test_change done");
    endtask

    task automatic test_saturate();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive_code(2, 1);
            if (d_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1 || d_cnt !== 16'd1 || d_stable !== 2'b10)
            $display("FAIL saturate got pulses=%0d cnt=%0d st=%b want 1/1/10", pulses, d_cnt, d_stable);
        else n_pass++;
        $display("test_saturate done");
    endtask

    task automatic test_illegal();
        do_reset();
        drive_code(3, 4);
        drive_code(2, 2);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (d_err !== 1'b1 || d_stable !== 2'b11 || d_cnt !== 16'd1 || d_valid !== 1'b1)
            $display("FAIL illegal_flag got err=%b st=%b cnt=%0d want 1/11/1", d_err, d_stable, d_cnt);
        else n_pass++;
        drive_code(2, 3);
        n_checks++;
        if (d_stable !== 2'b11 || d_pulse !== 1'b0)
            $display("FAIL illegal_runreset got st=%b p=%b want 11/0", d_stable, d_pulse);
        else n_pass++;
        drive_code(2, 1);
        n_checks++;
        if (d_stable !== 2'b10 || d_cnt !== 16'd2 || d_err !== 1'b1)
            $display("FAIL illegal_requal got st=%b cnt=%0d err=%b want 10/2/1", d_stable, d_cnt, d_err);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (d_err !== 1'b1 || d_stable !== 2'b10)
            $display("FAIL illegal_zero got err=%b st=%b want 1/10", d_err, d_stable);
        else n_pass++;
        $display("test_illegal done");
    endtask

    task automatic test_gaps();
        do_reset();
        drive_code(1, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive_code(1, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive_code(1, 1);
        n_checks++;
        if (d_stable !== 2'b00 || d_err !== 1'b0)
            $display("FAIL gaps_early got st=%b err=%b want 00/0", d_stable, d_err);
        else n_pass++;
        drive_code(1, 1);
        n_checks++;
        if (d_stable !== 2'b01 || d_pulse !== 1'b1 || d_err !== 1'b0)
            $display("FAIL gaps_qual got st=%b p=%b err=%b want 01/1/0", d_stable, d_pulse, d_err);
        else n_pass++;
        $display("test_gaps done");
    endtask

    task automatic test_reset_midrun();
        do_reset();
        drive_code(3, 2);
        do_reset();
        drive_code(3, 3);
        n_checks++;
        if (d_stable !== 2'b00 || d_valid !== 1'b0)
            $display("FAIL midrun_early got st=%b v=%b want 00/0", d_stable, d_valid);
        else n_pass++;
        drive_code(3, 1);
        n_checks++;
        if (d_stable !== 2'b11 || d_valid !== 1'b1)
            $display("FAIL midrun_qual got st=%b v=%b want 11/1", d_stable, d_valid);
        else n_pass++;
        $display("test_reset_midrun done");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int b = 0; b < 20; b++) begin
            int pulses = 0;
            for (int i = 0; i < 4; i++) begin
                drive_code((b % 2 == 0) ? 3 : 1, 1);
                if (d_pulse === 1'b1) pulses++;
            end
            n_checks++;
            if (pulses != 1 || w_cnt !== 4'(b + 1) || d_cnt !== 16'(b + 1))
                $display("FAIL wrap_blk%0d got pulses=%0d wcnt=%0d cnt=%0d want 1/%0d/%0d",
                         b, pulses, w_cnt, d_cnt, 4'(b + 1), b + 1);
            else n_pass++;
        end
        $display("test_wrap done");
    endtask

    task automatic test_random();
        int   code = 1;
        int   left = 0;
        int   r;
        logic [2:0] bad;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (left == 0) begin
                code = $urandom_range(1, 3);
                left = $urandom_range(1, 6);
            end
            r = $urandom_range(0, 99);
            if (r < 15) begin
                bad = 3'($urandom_range(0, 7));
                drive(1'b0, bad[2], bad[1], bad[0]);
            end else if (r < 18) begin
                do bad = 3'($urandom_range(0, 7)); while ($countones(bad) == 1);
                drive(1'b1, bad[2], bad[1], bad[0]);
            end else begin
                drive_code(code, 1);
                left--;
            end
            n_checks++;
            if ({d_stable, d_valid, d_pulse, d_cnt, d_err} !== {m_stable, m_valid, m_pulse, m_cnt, m_err})
                $display("FAIL rand_d4 cyc%0d got st=%b v=%b p=%b cnt=%0d err=%b want %b/%b/%b/%0d/%b",
                         c, d_stable, d_valid, d_pulse, d_cnt, d_err, m_stable, m_valid, m_pulse, m_cnt, m_err);
            else n_pass++;
            n_checks++;
            if ({w_stable, w_valid, w_pulse, w_cnt, w_err} !== {m_stable, m_valid, m_pulse, m_cnt[3:0], m_err})
                $display("FAIL rand_w cyc%0d got st=%b cnt=%0d want %b/%0d", c, w_stable, w_cnt, m_stable, m_cnt[3:0]);
            else n_pass++;
            n_checks++;
            if ({o_stable, o_valid, o_pulse, o_cnt, o_err} !== {s_stable, s_valid, s_pulse, s_cnt, m_err})
                $display("FAIL rand_d1 cyc%0d got st=%b p=%b cnt=%0d err=%b want %b/%b/%0d/%b",
                         c, o_stable, o_pulse, o_cnt, o_err, s_stable, s_pulse, s_cnt, m_err);
            else n_pass++;
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_change();
        test_saturate();
        test_illegal();
        test_gaps();
        test_reset_midrun();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
